// File: rtl/mcp23s17_spi_responder.sv
// MCP23S17 SPI mode-0 responder (BANK=0 map): register access, sequential pointer,
// interrupt-on-change with INTF/INTCAP latching.
module mcp23s17_spi_responder #(
  parameter logic [2:0]  HW_ADDR     = 3'b000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] gpio_a,
  input  logic [7:0] gpio_b,
  output logic       inta,
  output logic       intb
);

  typedef enum logic [2:0] {StIdle, StOpcode, StAddr, StData, StIgnore} state_e;

  localparam int unsigned InW = 19;
  // sck idles low, cs idles high
  localparam logic [InW-1:0] InRst = {1'b0, 1'b1, 1'b0, 16'h0000};

  logic [InW-1:0] in_raw, in_s;
  assign in_raw = {sck, cs, mosi, gpio_a, gpio_b};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign in_s = in_raw;
    end else begin : g_sync
      logic [InW-1:0] stg_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) stg_q[i] <= InRst;
        end else begin
          stg_q[0] <= in_raw;
          for (int i = 1; i < SYNC_STAGES; i++) stg_q[i] <= stg_q[i-1];
        end
      end
      assign in_s = stg_q[SYNC_STAGES-1];
    end
  endgenerate

  logic       sck_s, cs_s, mosi_s;
  logic [7:0] gpa_s, gpb_s;
  assign {sck_s, cs_s, mosi_s, gpa_s, gpb_s} = in_s;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, ptr_q, ptr_d;
  logic       rd_q, rd_d, miso_q, miso_d, oe_q, oe_d, sck_prev_q;
  logic [7:0] gpa_prev_q, gpb_prev_q;
  logic [7:0] iodir_a_q, iodir_a_d, iodir_b_q, iodir_b_d;
  logic [7:0] gpinten_a_q, gpinten_a_d, gpinten_b_q, gpinten_b_d;
  logic [7:0] iocon_q, iocon_d;
  logic [7:0] intf_a_q, intf_a_d, intf_b_q, intf_b_d;
  logic [7:0] intcap_a_q, intcap_a_d, intcap_b_q, intcap_b_d;
  logic       inta_q, inta_d, intb_q, intb_d;

  logic       sck_rise, sck_fall, byte_done, tx_load, clr_a, clr_b, pend_a, pend_b;
  logic [7:0] rx_byte, next_ptr, load_addr, load_data, mch_a, mch_b, base_a, base_b;

  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign byte_done = sck_rise && (cnt_q == 3'd7) && !cs_s;
  assign next_ptr  = iocon_q[5] ? ptr_q : ((ptr_q == 8'h15) ? 8'h00 : ptr_q + 8'd1);
  assign load_addr = (state_q == StAddr) ? rx_byte : next_ptr;
  assign tx_load   = byte_done && rd_q && ((state_q == StAddr) || (state_q == StData));
  assign clr_a     = tx_load && ((load_addr == 8'h10) || (load_addr == 8'h12));
  assign clr_b     = tx_load && ((load_addr == 8'h11) || (load_addr == 8'h13));
  assign mch_a     = (gpa_s ^ gpa_prev_q) & gpinten_a_q;
  assign mch_b     = (gpb_s ^ gpb_prev_q) & gpinten_b_q;
  assign base_a    = clr_a ? 8'h00 : intf_a_q;
  assign base_b    = clr_b ? 8'h00 : intf_b_q;
  assign pend_a    = |intf_a_q;
  assign pend_b    = |intf_b_q;

  always_comb begin
    load_data = 8'h00;
    case (load_addr)
      8'h00:        load_data = iodir_a_q;
      8'h01:        load_data = iodir_b_q;
      8'h04:        load_data = gpinten_a_q;
      8'h05:        load_data = gpinten_b_q;
      8'h0A, 8'h0B: load_data = iocon_q;
      8'h0E:        load_data = intf_a_q;
      8'h0F:        load_data = intf_b_q;
      8'h10:        load_data = intcap_a_q;
      8'h11:        load_data = intcap_b_q;
      8'h12:        load_data = gpa_s;
      8'h13:        load_data = gpb_s;
      default:      load_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rd_d        = rd_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    iodir_a_d   = iodir_a_q;
    iodir_b_d   = iodir_b_q;
    gpinten_a_d = gpinten_a_q;
    gpinten_b_d = gpinten_b_q;
    iocon_d     = iocon_q;
    if (cs_s) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      tx_d    = 8'h00;
      miso_d  = 1'b0;
    end else if (state_q == StIdle) begin
      state_d = StOpcode;
      cnt_d   = 3'd0;
    end else begin
      if (sck_rise) begin
        rx_d  = rx_byte;
        cnt_d = cnt_q + 3'd1;
      end
      if (sck_fall && ((state_q == StAddr) || (state_q == StData))) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (byte_done) begin
        case (state_q)
          StOpcode: begin
            if ((rx_byte[7:4] == 4'h4) && (!iocon_q[3] || (rx_byte[3:1] == HW_ADDR))) begin
              state_d = StAddr;
              rd_d    = rx_byte[0];
            end else begin
              state_d = StIgnore;
            end
          end
          StAddr: begin
            state_d = StData;
            ptr_d   = rx_byte;
          end
          StData: begin
            ptr_d = next_ptr;
            if (!rd_q) begin
              case (ptr_q)
                8'h00:        iodir_a_d   = rx_byte;
                8'h01:        iodir_b_d   = rx_byte;
                8'h04:        gpinten_a_d = rx_byte;
                8'h05:        gpinten_b_d = rx_byte;
                8'h0A, 8'h0B: iocon_d     = rx_byte & 8'h6A;
                default:      ;
              endcase
            end
          end
          default: ;
        endcase
      end
      if (tx_load) tx_d = load_data;
    end
    oe_d = !cs_s && ((state_d == StAddr) || (state_d == StData));
  end

  // A change arriving in the same cycle as a read-clear re-arms the flag.
  always_comb begin
    intf_a_d   = base_a;
    intcap_a_d = intcap_a_q;
    intf_b_d   = base_b;
    intcap_b_d = intcap_b_q;
    if ((base_a == 8'h00) && (mch_a != 8'h00)) begin
      intf_a_d   = mch_a;
      intcap_a_d = gpa_s;
    end
    if ((base_b == 8'h00) && (mch_b != 8'h00)) begin
      intf_b_d   = mch_b;
      intcap_b_d = gpb_s;
    end
    inta_d = iocon_q[6] ? (pend_a | pend_b) : pend_a;
    intb_d = iocon_q[6] ? (pend_a | pend_b) : pend_b;
    if (!iocon_q[1]) begin
      inta_d = ~inta_d;
      intb_d = ~intb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= 8'h00;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      sck_prev_q  <= 1'b0;
      gpa_prev_q  <= 8'h00;
      gpb_prev_q  <= 8'h00;
      iodir_a_q   <= 8'hFF;
      iodir_b_q   <= 8'hFF;
      gpinten_a_q <= 8'h00;
      gpinten_b_q <= 8'h00;
      iocon_q     <= 8'h00;
      intf_a_q    <= 8'h00;
      intf_b_q    <= 8'h00;
      intcap_a_q  <= 8'h00;
      intcap_b_q  <= 8'h00;
      inta_q      <= 1'b1;
      intb_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      sck_prev_q  <= sck_s;
      gpa_prev_q  <= gpa_s;
      gpb_prev_q  <= gpb_s;
      iodir_a_q   <= iodir_a_d;
      iodir_b_q   <= iodir_b_d;
      gpinten_a_q <= gpinten_a_d;
      gpinten_b_q <= gpinten_b_d;
      iocon_q     <= iocon_d;
      intf_a_q    <= intf_a_d;
      intf_b_q    <= intf_b_d;
      intcap_a_q  <= intcap_a_d;
      intcap_b_q  <= intcap_b_d;
      inta_q      <= inta_d;
      intb_q      <= intb_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign inta    = inta_q;
  assign intb    = intb_q;

endmodule
